// File: rtl/pulse_req_pkg.sv
// rtl/pulse_req_pkg.sv - shared state encoding and timer sizing for pulse_req_stretcher
package pulse_req_pkg;

  // Request sequencer states: IDLE (req low, nothing in flight), HIGH (req asserted), LOW (mandatory gap)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Timer width: must hold max(HOLD, GAP) - 1, sized as $clog2(max(HOLD, GAP) + 1)
  function automatic int timer_w(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pulse_req_stretcher.sv
// rtl/pulse_req_stretcher.sv - event pulse to held request level generator; optional ack handshake via PULSE_REQ_ACK_EN
module pulse_req_stretcher
  import pulse_req_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pulse_i,
`ifdef PULSE_REQ_ACK_EN
  input  logic             ack_i,
`endif
  input  logic             clr_i,
  output logic             req_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int               TMR_W   = timer_w(HOLD, GAP);
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   pend_q, pend_d, pend_base;
  logic               ovf_q, ovf_d;
  logic               req_q, busy_q;
  logic               avail;
  logic               launch;
  logic               ack_ok;

  // Without the handshake, HIGH ends purely on the hold timer
`ifdef PULSE_REQ_ACK_EN
  assign ack_ok = ack_i;
`else
  assign ack_ok = 1'b1;
`endif

  // A clear discards queued events first; a same-cycle pulse is then counted on top
  assign pend_base = clr_i ? '0 : pend_q;
  assign avail     = (pend_base != '0) | pulse_i;

  // Sequencer next state and timer; launches only from IDLE or the final LOW cycle
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (avail) begin
          launch  = 1'b1;
          state_d = HIGH;
          tmr_d   = HOLD_LD;
        end
      end
      HIGH: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (ack_ok) begin
          state_d = LOW;
          tmr_d   = GAP_LD;
        end
      end
      LOW: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TMR_W'(1);
        end else if (avail) begin
          launch  = 1'b1;
          state_d = HIGH;
          tmr_d   = HOLD_LD;
        end else begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Pending counter: +pulse -launch, saturating at max with a sticky overflow on a drop
  always_comb begin
    pend_d = pend_base;
    ovf_d  = clr_i ? 1'b0 : ovf_q;
    if (pulse_i && !launch) begin
      if (pend_base == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_base + CNT_W'(1);
      end
    end else if (!pulse_i && launch) begin
      pend_d = pend_base - CNT_W'(1);
    end
  end

  // State, timer, counter and registered outputs all advance on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      req_q   <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign req_o      = req_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_pulse_req_stretcher.sv
// tb/tb_pulse_req_stretcher.sv - self-checking bench for pulse_req_stretcher (ack path exercised when PULSE_REQ_ACK_EN is defined)
module tb_pulse_req_stretcher;

  localparam int CNT_W = 2;
  localparam int HOLD  = 2;
  localparam int GAP   = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             pulse;
  logic             clr;
  logic             ack;
  logic             req;
  logic [CNT_W-1:0] pend;
  logic             ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Reference: position within the current request (0 = idle, 1..HOLD high, HOLD+1..HOLD+GAP low)
  int m_pos;
  int m_pend;
  bit m_ovf;

  typedef struct {
    bit p;
    bit c;
    bit req;
    int pend;
    bit ovf;
    bit busy;
  } vec_t;

  vec_t tbl[$];

  pulse_req_stretcher #(.CNT_W(CNT_W), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pulse_i    (pulse),
`ifdef PULSE_REQ_ACK_EN
    .ack_i      (ack),
`endif
    .clr_i      (clr),
    .req_o      (req),
    .pending_o  (pend),
    .overflow_o (ovf),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_pend = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step(input bit p, input bit c, input bit a);
    int pe;
    bit av;
    bit l;
    pe = c ? 0 : m_pend;
    av = (pe != 0) || p;
    l  = av && ((m_pos == 0) || (m_pos == HOLD + GAP));
    if (c) m_ovf = 1'b0;
    if (l) m_pos = 1;
    else if (m_pos == 0 || m_pos == HOLD + GAP) m_pos = 0;
    else if (m_pos == HOLD && !a) m_pos = HOLD;
    else m_pos = m_pos + 1;
    if (p && !l && pe == MAXC) m_ovf = 1'b1;
    else m_pend = pe + int'(p) - int'(l);
  endtask

  task automatic step(input bit p, input bit c);
    bit a;
    pulse = p;
    clr   = c;
`ifdef PULSE_REQ_ACK_EN
    a = ack;
`else
    a = 1'b1;
`endif
    @(posedge clk);
    model_step(p, c, a);
    #1;
    check("model_req", req, (m_pos >= 1 && m_pos <= HOLD));
    check("model_pending", pend, m_pend);
    check("model_overflow", ovf, m_ovf);
    check("model_busy", busy, (m_pos != 0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pulse   = 1'b0;
    clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("reset_req", req, 0);
    check("reset_pending", pend, 0);
    check("reset_overflow", ovf, 0);
    check("reset_busy", busy, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    ack = 1'b1;
    // single pulse: high two cycles, low two cycles, then idle
    tbl.push_back('{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0});
    // three consecutive pulses: highs at cycles 1, 5, 9; pending peaks at 2
    tbl.push_back('{1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0});

    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].p, tbl[i].c);
      check("tbl_req", req, tbl[i].req);
      check("tbl_pending", pend, tbl[i].pend);
      check("tbl_overflow", ovf, tbl[i].ovf);
      check("tbl_busy", busy, tbl[i].busy);
    end

    // saturation, launch coincident with pulse at max, then clear during an in-flight request
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      if (i == 3) check("sat_fill_pending", pend, 3);
      if (i == 4) begin
        check("launch_at_max_pending", pend, 3);
        check("launch_at_max_overflow", ovf, 0);
      end
    end
    check("sat_pending", pend, 3);
    check("sat_overflow", ovf, 1);
    step(1'b0, 1'b1);
    check("clr_pending", pend, 0);
    check("clr_overflow", ovf, 0);
    check("clr_inflight_busy", busy, 1);
    n = 0;
    while (busy && n < 20) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("clr_drain_busy", busy, 0);
    check("clr_drain_cycles", n, 2);

    // asynchronous reset in HIGH with two events queued
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("pre_rst_req", req, 1);
    check("pre_rst_pending", pend, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_req", req, 0);
    check("async_rst_pending", pend, 0);
    check("async_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0);
    check("post_rst_req", req, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("post_rst_low", req, 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("post_rst_idle", busy, 0);

`ifdef PULSE_REQ_ACK_EN
    // ack held low for ten cycles of HIGH, then high: eleven high cycles
    ack = 1'b0;
    n = 0;
    step(1'b1, 1'b0);
    if (req) n++;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      if (req) n++;
    end
    ack = 1'b1;
    step(1'b0, 1'b0);
    check("ack_drop_req", req, 0);
    check("ack_high_cycles", n, 11);
    ack = 1'b0;
    step(1'b0, 1'b0);
    ack = 1'b1;
    step(1'b0, 1'b0);
    check("ack_in_low_idle", busy, 0);
`endif

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
`ifdef PULSE_REQ_ACK_EN
      ack = ($urandom_range(0, 3) != 0);
`endif
      step($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_req_stretcher.md
# pulse_req_stretcher

Single-clock event-to-request generator: turns single-cycle event pulses from the fast PIO/DMA-side logic into well-formed request levels that a slower, edge-aligned consumer can observe. The consumer recovers one pulse per request with a rising-edge detector. Each request is held high for a guaranteed minimum time, then returned low for a guaranteed gap. Events that arrive while a request is in flight are queued in a saturating pending counter, so back-to-back pulses are never merged.

## Interface
Parameters:
- CNT_W, 4, width of pending-event counter; max queued = 2^CNT_W-1
- HOLD, 2, minimum cycles req_o stays high per event (>=1); set >= clock ratio to the consumer
- GAP, 2, cycles req_o stays low between events (>=1); set >= clock ratio to the consumer

Ports:
- clk  in  1  sole clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- pulse_i  in  1  event strobe; each high cycle = one event
- ack_i  in  1  consumer acknowledge level (present only with PULSE_REQ_ACK_EN)
- clr_i  in  1  synchronous clear of pending count and overflow flag
- req_o  out  1  registered request level to consumer
- pending_o  out  CNT_W  events accepted but not yet launched
- overflow_o  out  1  sticky flag; set when an event is dropped at saturation
- busy_o  out  1  high whenever state != IDLE

## Operation
- Reset values: state IDLE, req_o 0, pending_o 0, overflow_o 0, busy_o 0, timer 0.
- States: IDLE (req_o=0), HIGH (req_o=1), LOW (req_o=0).
- Each cycle, avail = (pending != 0) | pulse_i.
- A launch occurs in two cases:
  - IDLE with avail: go to HIGH; timer = HOLD-1.
  - Final LOW cycle with avail: go directly to HIGH, with no IDLE cycle.
- Final LOW cycle with !avail: go to IDLE.
- Counter update: pending_next = pending + pulse_i - launch.
  - Simultaneous pulse and launch: count unchanged, never overflow.
  - pulse_i at pending = MAX with no launch: event dropped, pending stays MAX, overflow_o <= 1.
- HIGH, no ack mode: count the timer down; on its last cycle, go to LOW with timer = GAP-1.
- LOW: count the timer down, then decide per the launch rules above.
- clr_i:
  - pending <= 0 and overflow_o <= 0.
  - A HIGH/LOW sequence already in progress runs to completion.
  - A pulse_i in the same cycle is applied after the clear: pending = 1, or a launch if a launch occurs that cycle.
- pulse_i while in HIGH or LOW: queued only, with no effect on the current timer.

## Timing
- Latency: pulse_i high at edge n (IDLE, pending 0) gives req_o high from cycle n+1.
- Nominal sequence, HOLD=2 / GAP=2: req_o high cycles 1–2, low 3–4; a queued event raises req_o at cycle 5.
- Throughput: one event per HOLD+GAP cycles. Sustained pulse_i at a higher rate fills the counter and then sets overflow.
- pending_o, overflow_o and busy_o are registered and update on the same edge as the state.
- Reset asserted mid-operation clears everything immediately. Queued events are lost, and req_o drops asynchronously.

## Configuration
- PULSE_REQ_ACK_EN defined:
  - ack_i exists.
  - HIGH exits only when at least HOLD cycles have elapsed and ack_i is sampled high.
  - ack_i outside HIGH is ignored.
  - A held-low ack keeps req_o high indefinitely; pending continues to accumulate.
- PULSE_REQ_ACK_EN undefined:
  - No ack_i port.
  - HIGH lasts exactly HOLD cycles.

## Structure
- Shared package pulse_req_pkg holds:
  - the state enum typedef (IDLE, HIGH, LOW, 2-bit encoding);
  - the timer-width helper constant, $clog2 of max(HOLD,GAP)+1.
- Single module, no sub-module. The timer and the counter are both inline and small.

## Test plan
- Single pulse, HOLD=2/GAP=2: pulse at cycle 0 -> req_o=1 cycles 1–2, 0 after; busy_o back to 0 at cycle 5; pending_o stays 0.
- Three consecutive pulse cycles -> three distinct req_o highs starting at cycles 1, 5, 9; pending_o peaks at 2.
- CNT_W=2, 6 back-to-back pulses while busy -> pending_o saturates at 3, overflow_o=1; clr_i -> pending 0 and overflow 0, while the in-flight request still completes.
- Pulse coincident with launch in the final LOW cycle with pending=3 (MAX) -> pending remains 3, overflow_o stays 0.
- ACK_EN build, ack_i held 0 for 10 cycles then 1 -> req_o high 11 cycles and drops on the edge after ack is sampled; ack pulse during LOW has no effect.
- reset_n pulsed low during HIGH with pending=2 -> req_o, pending_o, busy_o immediately 0; next pulse behaves as in the first scenario.
